// File: rtl/cnn_pkg.sv
// Shared CNN geometry constants and small helpers
// for the conv -> pool -> fc datapath.
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int CH     = 3;

    // fc_layer consumes exactly this many pooled values per frame
    localparam int POOL_OUTS = CH * (IMG_H / 2) * (IMG_W / 2);

    function automatic logic signed [DATA_W-1:0] max2(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding horizontal maxima
// of the even row of each pooling window pair.
module pool_line_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [W-1:0]  i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/maxpool_flatten.sv
// Streaming ReLU + 2x2/stride-2 max-pool, emitting pooled
// values serially in channel/row/column order for fc_layer.
module maxpool_flatten
    import cnn_pkg::max2;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int CH     = cnn_pkg::CH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic                     sof_in,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     frame_done,
    output logic                     resync_err
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LD = IMG_W / 2;
    localparam int IW = (LD > 1) ? $clog2(LD) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH - 1);

    logic [XW-1:0] r_x, w_x, w_x_nx;
    logic [RW-1:0] r_r, w_r, w_r_nx;
    logic [CW-1:0] r_c, w_c, w_c_nx;

    logic signed [DATA_W-1:0] r_h;
    logic signed [DATA_W-1:0] w_px;
    logic signed [DATA_W-1:0] w_hmax;
    logic signed [DATA_W-1:0] w_res;
    logic [DATA_W-1:0]        w_lb_rd;
    logic [IW-1:0]            w_idx;

    logic w_sof, w_lb_we, w_emit, w_last, w_resync;

    // A qualified sof forces this pixel to index 0, which also
    // abandons any half-built window without extra bookkeeping.
    assign w_sof = valid_in & sof_in;
    assign w_x   = w_sof ? '0 : r_x;
    assign w_r   = w_sof ? '0 : r_r;
    assign w_c   = w_sof ? '0 : r_c;
    assign w_idx = IW'(w_x >> 1);

    assign w_px   = data_in[DATA_W-1] ? '0 : data_in;
    assign w_hmax = max2(r_h, w_px);
    assign w_res  = max2($signed(w_lb_rd), w_hmax);

    assign w_lb_we  = valid_in & w_x[0] & ~w_r[0];
    assign w_emit   = valid_in & w_x[0] & w_r[0];
    assign w_last   = (w_x == X_LAST) && (w_r == R_LAST) && (w_c == C_LAST);
    assign w_resync = w_sof & (|{r_x, r_r, r_c});

    always_comb begin
        w_x_nx = w_x + 1'b1;
        w_r_nx = w_r;
        w_c_nx = w_c;
        if (w_x == X_LAST) begin
            w_x_nx = '0;
            w_r_nx = w_r + 1'b1;
            if (w_r == R_LAST) begin
                w_r_nx = '0;
                w_c_nx = (w_c == C_LAST) ? '0 : w_c + 1'b1;
            end
        end
    end

    pool_line_buf #(
        .DEPTH (LD),
        .W     (DATA_W)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_lb_we),
        .i_widx  (w_idx),
        .i_wdata (w_hmax),
        .i_ridx  (w_idx),
        .o_rdata (w_lb_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_r        <= '0;
            r_c        <= '0;
            r_h        <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            valid_out  <= w_emit;
            frame_done <= w_emit & w_last;
            resync_err <= w_resync;
            if (valid_in) begin
                r_x <= w_x_nx;
                r_r <= w_r_nx;
                r_c <= w_c_nx;
                if (!w_x[0]) begin
                    r_h <= w_px;
                end
            end
            if (w_emit) begin
                data_out <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Self-checking bench for maxpool_flatten against a
// whole-image reference model.
module tb_maxpool_flatten;
    import cnn_pkg::*;

    localparam int FRAME = CH * IMG_H * IMG_W;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     valid_in = 1'b0;
    logic                     sof_in = 1'b0;
    logic signed [DATA_W-1:0] data_in = '0;
    logic                     valid_out;
    logic signed [DATA_W-1:0] data_out;
    logic                     frame_done;
    logic                     resync_err;

    always #5 clk = ~clk;

    maxpool_flatten dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .sof_in     (sof_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .frame_done (frame_done),
        .resync_err (resync_err)
    );

    int checks = 0;
    int errors = 0;

    int img [CH][IMG_H][IMG_W];
    int m_idx  = 0;
    int m_last = 0;
    bit gaps   = 0;

    int outq [$];
    int ramp_ref [$];
    int fdq [$];
    int n_fd  = 0;
    int n_res = 0;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic observe(input bit ev, input int ed,
                           input bit efd, input bit eres);
        chk("valid_out", {31'd0, valid_out}, {31'd0, ev});
        if (ev) m_last = ed;
        chk("data_out", $signed(data_out), m_last);
        chk("frame_done", {31'd0, frame_done}, {31'd0, efd});
        chk("resync_err", {31'd0, resync_err}, {31'd0, eres});
        if (valid_out === 1'b1) outq.push_back(int'($signed(data_out)));
        if (frame_done === 1'b1) begin
            n_fd++;
            fdq.push_back(outq.size());
        end
        if (resync_err === 1'b1) n_res++;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        sof_in   = 1'b0;
        @(posedge clk);
        #1;
        observe(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic push(input int d, input bit sof);
        int  c, r, x, ed;
        bit  ev, efd, eres;
        if (gaps && ($urandom % 2 == 1)) begin
            repeat ($urandom_range(0, 7)) idle();
        end
        eres = sof && (m_idx != 0);
        if (sof) m_idx = 0;
        c = m_idx / (IMG_H * IMG_W);
        r = (m_idx / IMG_W) % IMG_H;
        x = m_idx % IMG_W;
        img[c][r][x] = relu(d);
        ev = (r % 2 == 1) && (x % 2 == 1);
        ed = 0;
        if (ev) ed = max4(img[c][r-1][x-1], img[c][r-1][x],
                          img[c][r][x-1], img[c][r][x]);
        efd = (m_idx == FRAME - 1);
        m_idx = (m_idx + 1) % FRAME;
        valid_in = 1'b1;
        sof_in   = sof;
        data_in  = DATA_W'(d);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        observe(ev, ed, efd, eres);
    endtask

    task automatic send_ramp(input bit sof);
        for (int i = 0; i < FRAME; i++) begin
            push((i / (IMG_H * IMG_W)) * 10 + ((i / IMG_W) % IMG_H) * 8
                 + (i % IMG_W), sof && (i == 0));
        end
    endtask

    task automatic send_rand(input int n, input bit sof);
        for (int i = 0; i < n; i++) begin
            push(int'($urandom_range(0, 255)) - 128, sof && (i == 0));
        end
    endtask

    task automatic cmp_ramp(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < POOL_OUTS; i++) begin
            if (i >= outq.size() || outq[i] != ramp_ref[i]) mism++;
        end
        chk({tag, "_count"}, outq.size(), POOL_OUTS);
        chk({tag, "_seq"}, mism, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, {31'd0, valid_out}, 0);
        chk({tag, "_data"}, $signed(data_out), 0);
        chk({tag, "_fd"}, {31'd0, frame_done}, 0);
        chk({tag, "_res"}, {31'd0, resync_err}, 0);
    endtask

    initial begin
        int zeros, threes, negs, d;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // ramp frame
        outq.delete();
        n_fd = 0;
        send_ramp(1'b1);
        chk("ramp_count", outq.size(), POOL_OUTS);
        if (outq.size() == POOL_OUTS) begin
            chk("ramp_first", outq[0], 9);
            chk("ramp_second", outq[1], 11);
            chk("ramp_row1", outq[4], 25);
            chk("ramp_ch0_last", outq[15], 63);
            chk("ramp_last", outq[47], 83);
        end
        chk("ramp_fd", n_fd, 1);
        ramp_ref = outq;
        repeat (3) idle();

        // all-negative frame with one -128/+3 window
        outq.delete();
        for (int i = 0; i < FRAME; i++) begin
            d = -5;
            if (i == 84) d = -128;
            if (i == 93) d = 3;
            push(d, i == 0);
        end
        zeros = 0;
        threes = 0;
        negs = 0;
        foreach (outq[i]) begin
            if (outq[i] == 0) zeros++;
            if (outq[i] == 3) threes++;
            if (outq[i] < 0) negs++;
        end
        chk("neg_zeros", zeros, 47);
        chk("neg_threes", threes, 1);
        chk("neg_negs", negs, 0);

        // ramp with random valid gaps
        outq.delete();
        n_fd = 0;
        gaps = 1;
        send_ramp(1'b1);
        gaps = 0;
        cmp_ramp("gaps");
        chk("gaps_fd", n_fd, 1);

        // mid-frame resync: 100 pixels hold 24 complete windows
        outq.delete();
        n_res = 0;
        n_fd = 0;
        send_rand(100, 1'b0);
        chk("pre_sof_outs", outq.size(), 24);
        outq.delete();
        send_ramp(1'b1);
        chk("resync_pulses", n_res, 1);
        cmp_ramp("resync");
        chk("resync_fd", n_fd, 1);

        // asynchronous reset mid-frame
        send_rand(70, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        m_idx = 0;
        m_last = 0;
        chk_quiet("rst_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_quiet("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        outq.delete();
        n_fd = 0;
        n_res = 0;
        send_ramp(1'b0);
        cmp_ramp("post_rst");
        chk("post_rst_fd", n_fd, 1);
        chk("post_rst_res", n_res, 0);

        // back-to-back random frames
        outq.delete();
        fdq.delete();
        n_fd = 0;
        send_rand(FRAME, 1'b1);
        send_rand(FRAME, 1'b1);
        repeat (2) idle();
        chk("b2b_count", outq.size(), 2 * POOL_OUTS);
        chk("b2b_fd", n_fd, 2);
        if (fdq.size() == 2) begin
            chk("b2b_fd0_pos", fdq[0], POOL_OUTS);
            chk("b2b_fd1_pos", fdq[1], 2 * POOL_OUTS);
        end
        chk("b2b_res", n_res, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
